// File: rtl/mpa_mips_reg_wb.sv
// Writeback queue: round-robin ALU/LSU grants into a FIFO, one register-file write per cycle, commit one edge after accept.
// READY drops only when full (a same-cycle pop frees nothing); MPA_WB_FWD_EN forwards pending data, else HAZn flags stalls.
module mpa_mips_reg_wb #(
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       HW_RSTn,
   input  logic                       ALU_VALID,
   output logic                       ALU_READY,
   input  logic [4:0]                 ALU_ADDR,
   input  logic [31:0]                ALU_DATA,
   input  logic                       LSU_VALID,
   output logic                       LSU_READY,
   input  logic [4:0]                 LSU_ADDR,
   input  logic [31:0]                LSU_DATA,
   input  logic                       RF_HOLD,
   output logic [4:0]                 RF_A2,
   output logic [31:0]                RF_DIN,
   output logic                       RF_WE,
   input  logic [4:0]                 RD_A0,
   input  logic [4:0]                 RD_A1,
   input  logic [31:0]                RF_DOUT0,
   input  logic [31:0]                RF_DOUT1,
   output logic [31:0]                OP0,
   output logic [31:0]                OP1,
   output logic                       HAZ0,
   output logic                       HAZ1,
   output logic [$clog2(DEPTH):0]     PEND_CNT
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   wb_t           q [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          rr_lsu;
   logic          not_full;
   logic          empty;
   logic          push;
   logic          pop;
   wb_t           win;

   assign not_full  = cnt < CW'(DEPTH);
   assign empty     = (cnt == '0);
   assign ALU_READY = not_full & ALU_VALID & (~LSU_VALID | ~rr_lsu);
   assign LSU_READY = not_full & LSU_VALID & (~ALU_VALID | rr_lsu);
   assign win       = ALU_READY ? {ALU_ADDR, ALU_DATA} : {LSU_ADDR, LSU_DATA};
   // r0 writes complete the handshake but never occupy a slot
   assign push      = (ALU_READY | LSU_READY) & (win.addr != 5'd0);
   assign RF_WE     = ~empty & ~RF_HOLD;
   assign pop       = RF_WE;
   assign RF_A2     = empty ? 5'd0 : q[rd_ptr].addr;
   assign RF_DIN    = empty ? 32'd0 : q[rd_ptr].data;
   assign PEND_CNT  = cnt;

   always_ff @(posedge CLK or negedge HW_RSTn) begin
      if (!HW_RSTn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         rr_lsu <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (ALU_VALID && LSU_VALID && not_full) rr_lsu <= ~rr_lsu;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) q[wr_ptr] <= win;
   end

   logic hit0;
   logic hit1;
`ifdef MPA_WB_FWD_EN
   logic [31:0] fwd0;
   logic [31:0] fwd1;
`endif

   // Scan oldest to youngest so the last match is the youngest entry
   always_comb begin
      logic [PW-1:0] idx;
      hit0 = 1'b0;
      hit1 = 1'b0;
`ifdef MPA_WB_FWD_EN
      fwd0 = 32'd0;
      fwd1 = 32'd0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + PW'(k);
         if (CW'(k) < cnt) begin
            if (q[idx].addr == RD_A0) begin
               hit0 = 1'b1;
`ifdef MPA_WB_FWD_EN
               fwd0 = q[idx].data;
`endif
            end
            if (q[idx].addr == RD_A1) begin
               hit1 = 1'b1;
`ifdef MPA_WB_FWD_EN
               fwd1 = q[idx].data;
`endif
            end
         end
      end
   end

`ifdef MPA_WB_FWD_EN
   assign OP0  = (RD_A0 == 5'd0) ? 32'd0 : (hit0 ? fwd0 : RF_DOUT0);
   assign OP1  = (RD_A1 == 5'd0) ? 32'd0 : (hit1 ? fwd1 : RF_DOUT1);
   assign HAZ0 = 1'b0;
   assign HAZ1 = 1'b0;
`else
   assign OP0  = (RD_A0 == 5'd0) ? 32'd0 : RF_DOUT0;
   assign OP1  = (RD_A1 == 5'd0) ? 32'd0 : RF_DOUT1;
   assign HAZ0 = (RD_A0 != 5'd0) & hit0;
   assign HAZ1 = (RD_A1 != 5'd0) & hit1;
`endif

endmodule

// File: tb/tb_mpa_mips_reg_wb.sv
// Directed bench for mpa_mips_reg_wb (DEPTH=4); expectations follow MPA_WB_FWD_EN when defined.
module tb_mpa_mips_reg_wb;
   logic        CLK = 1'b0;
   logic        HW_RSTn;
   logic        ALU_VALID, ALU_READY, LSU_VALID, LSU_READY;
   logic [4:0]  ALU_ADDR, LSU_ADDR, RF_A2, RD_A0, RD_A1;
   logic [31:0] ALU_DATA, LSU_DATA, RF_DIN, RF_DOUT0, RF_DOUT1, OP0, OP1;
   logic        RF_HOLD, RF_WE, HAZ0, HAZ1;
   logic [2:0]  PEND_CNT;

   int n_cmp = 0;
   int n_err = 0;
   logic [36:0] wlog [$];

   mpa_mips_reg_wb #(.DEPTH(4)) dut (
      .CLK(CLK), .HW_RSTn(HW_RSTn),
      .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
      .LSU_VALID(LSU_VALID), .LSU_READY(LSU_READY), .LSU_ADDR(LSU_ADDR), .LSU_DATA(LSU_DATA),
      .RF_HOLD(RF_HOLD), .RF_A2(RF_A2), .RF_DIN(RF_DIN), .RF_WE(RF_WE),
      .RD_A0(RD_A0), .RD_A1(RD_A1), .RF_DOUT0(RF_DOUT0), .RF_DOUT1(RF_DOUT1),
      .OP0(OP0), .OP1(OP1), .HAZ0(HAZ0), .HAZ1(HAZ1), .PEND_CNT(PEND_CNT)
   );

   always #5 CLK = ~CLK;

   // Record each register-file write just before the edge that commits it
   always begin
      @(negedge CLK);
      #4;
      if (RF_WE === 1'b1) wlog.push_back({RF_A2, RF_DIN});
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (PEND_CNT == 3'd0) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic test_reset();
      wlog.delete();
      HW_RSTn = 1'b0; ALU_VALID = 1'b0; LSU_VALID = 1'b1; LSU_ADDR = 5'd3; LSU_DATA = 32'h11;
      RF_HOLD = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      n_cmp++; if (PEND_CNT !== 3'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", PEND_CNT); end
      n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", RF_WE); end
      n_cmp++; if (LSU_READY !== 1'b1) begin n_err++; $display("FAIL rst_lsu_rdy: got %b want 1", LSU_READY); end
      n_cmp++; if (ALU_READY !== 1'b0) begin n_err++; $display("FAIL rst_alu_rdy: got %b want 0", ALU_READY); end
      n_cmp++; if (RF_A2 !== 5'd0 || RF_DIN !== 32'd0) begin n_err++; $display("FAIL rst_head: got %0d/%h want 0/0", RF_A2, RF_DIN); end
      HW_RSTn = 1'b1;
      @(negedge CLK);
      LSU_VALID = 1'b0;
      #1;
      n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL first_we: got %b want 1", RF_WE); end
      n_cmp++; if (RF_A2 !== 5'd3) begin n_err++; $display("FAIL first_a2: got %0d want 3", RF_A2); end
      n_cmp++; if (RF_DIN !== 32'h11) begin n_err++; $display("FAIL first_din: got %h want 11", RF_DIN); end
      n_cmp++; if (PEND_CNT !== 3'd1) begin n_err++; $display("FAIL first_cnt: got %0d want 1", PEND_CNT); end
      @(negedge CLK);
      #1;
      n_cmp++; if (PEND_CNT !== 3'd0) begin n_err++; $display("FAIL first_cnt_after: got %0d want 0", PEND_CNT); end
      n_cmp++; if (wlog.size() !== 1) begin n_err++; $display("FAIL first_log_n: got %0d want 1", wlog.size()); end
      else begin
         n_cmp++; if (wlog[0] !== {5'd3, 32'h11}) begin n_err++; $display("FAIL first_log: got %h want %h", wlog[0], {5'd3, 32'h11}); end
      end
   endtask

   task automatic test_round_robin();
      logic [36:0] exp [4];
      bit ok;
      exp = '{{5'd5, 32'h50}, {5'd6, 32'h60}, {5'd5, 32'h51}, {5'd6, 32'h61}};
      wlog.delete();
      @(negedge CLK);
      RF_HOLD = 1'b1;
      ALU_VALID = 1'b1; ALU_ADDR = 5'd5; ALU_DATA = 32'h50;
      LSU_VALID = 1'b1; LSU_ADDR = 5'd6; LSU_DATA = 32'h60;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge CLK);
         if (i == 1) ALU_DATA = 32'h51;
         if (i == 2) LSU_DATA = 32'h61;
         #1;
         n_cmp++; if (ALU_READY !== (i % 2 == 0) || LSU_READY !== (i % 2 == 1)) begin
            n_err++; $display("FAIL rr_grant%0d: got alu=%b lsu=%b want alu=%b", i, ALU_READY, LSU_READY, (i % 2 == 0));
         end
         n_cmp++; if (PEND_CNT !== 3'(i)) begin n_err++; $display("FAIL rr_cnt%0d: got %0d want %0d", i, PEND_CNT, i); end
      end
      @(negedge CLK);
      #1;
      n_cmp++; if (PEND_CNT !== 3'd4) begin n_err++; $display("FAIL rr_full_cnt: got %0d want 4", PEND_CNT); end
      n_cmp++; if (ALU_READY !== 1'b0 || LSU_READY !== 1'b0) begin n_err++; $display("FAIL rr_full_rdy: got %b%b want 00", ALU_READY, LSU_READY); end
      n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL rr_hold_we: got %b want 0", RF_WE); end
      ALU_VALID = 1'b0; LSU_VALID = 1'b0; RF_HOLD = 1'b0;
      #1;
      n_cmp++; if (RF_WE !== 1'b1 || RF_A2 !== 5'd5 || RF_DIN !== 32'h50) begin
         n_err++; $display("FAIL rr_head: got we=%b %0d/%h want 1 5/50", RF_WE, RF_A2, RF_DIN);
      end
      drain(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_drain: got cnt %0d want 0", PEND_CNT); end
      n_cmp++; if (wlog.size() !== 4) begin n_err++; $display("FAIL rr_log_n: got %0d want 4", wlog.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++; if (wlog[i] !== exp[i]) begin n_err++; $display("FAIL rr_log%0d: got %h want %h", i, wlog[i], exp[i]); end
         end
      end
   endtask

   task automatic test_reg0();
      wlog.delete();
      @(negedge CLK);
      RF_HOLD = 1'b0; ALU_VALID = 1'b1; ALU_ADDR = 5'd0; ALU_DATA = 32'hFFFF_FFFF;
      RD_A0 = 5'd0; RF_DOUT0 = 32'h1234;
      #1;
      n_cmp++; if (ALU_READY !== 1'b1) begin n_err++; $display("FAIL r0_rdy: got %b want 1", ALU_READY); end
      @(negedge CLK);
      ALU_VALID = 1'b0;
      #1;
      n_cmp++; if (PEND_CNT !== 3'd0) begin n_err++; $display("FAIL r0_cnt: got %0d want 0", PEND_CNT); end
      n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL r0_we: got %b want 0", RF_WE); end
      n_cmp++; if (OP0 !== 32'd0 || HAZ0 !== 1'b0) begin n_err++; $display("FAIL r0_op: got %h haz %b want 0 0", OP0, HAZ0); end
      @(negedge CLK);
      #1;
      n_cmp++; if (wlog.size() !== 0) begin n_err++; $display("FAIL r0_log: got %0d writes want 0", wlog.size()); end
   endtask

   task automatic test_forward();
      bit ok;
      wlog.delete();
      @(negedge CLK);
      RF_HOLD = 1'b1; ALU_VALID = 1'b1; ALU_ADDR = 5'd7; ALU_DATA = 32'hA;
      RD_A0 = 5'd7; RF_DOUT0 = 32'h5; RD_A1 = 5'd9; RF_DOUT1 = 32'h99;
      #1;
      n_cmp++; if (OP0 !== 32'h5 || HAZ0 !== 1'b0) begin n_err++; $display("FAIL fw_accepting: got %h haz %b want 5 0", OP0, HAZ0); end
      @(negedge CLK);
      ALU_DATA = 32'hB;
      #1;
`ifdef MPA_WB_FWD_EN
      n_cmp++; if (OP0 !== 32'hA || HAZ0 !== 1'b0) begin n_err++; $display("FAIL fw_one: got %h haz %b want a 0", OP0, HAZ0); end
`else
      n_cmp++; if (OP0 !== 32'h5 || HAZ0 !== 1'b1) begin n_err++; $display("FAIL fw_one: got %h haz %b want 5 1", OP0, HAZ0); end
`endif
      @(negedge CLK);
      ALU_VALID = 1'b0;
      #1;
`ifdef MPA_WB_FWD_EN
      n_cmp++; if (OP0 !== 32'hB || HAZ0 !== 1'b0) begin n_err++; $display("FAIL fw_youngest: got %h haz %b want b 0", OP0, HAZ0); end
`else
      n_cmp++; if (OP0 !== 32'h5 || HAZ0 !== 1'b1) begin n_err++; $display("FAIL fw_youngest: got %h haz %b want 5 1", OP0, HAZ0); end
`endif
      n_cmp++; if (OP1 !== 32'h99 || HAZ1 !== 1'b0) begin n_err++; $display("FAIL fw_miss: got %h haz %b want 99 0", OP1, HAZ1); end
      n_cmp++; if (PEND_CNT !== 3'd2) begin n_err++; $display("FAIL fw_cnt: got %0d want 2", PEND_CNT); end
      RF_HOLD = 1'b0;
      @(negedge CLK);
      #1;
      n_cmp++; if (RF_WE !== 1'b1 || RF_DIN !== 32'hB) begin n_err++; $display("FAIL fw_head_we: got %b %h want 1 b", RF_WE, RF_DIN); end
`ifdef MPA_WB_FWD_EN
      n_cmp++; if (OP0 !== 32'hB) begin n_err++; $display("FAIL fw_commit: got %h want b", OP0); end
`else
      n_cmp++; if (HAZ0 !== 1'b1) begin n_err++; $display("FAIL fw_commit: got haz %b want 1", HAZ0); end
`endif
      drain(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL fw_drain: got cnt %0d want 0", PEND_CNT); end
      n_cmp++; if (wlog.size() !== 2 || wlog[0] !== {5'd7, 32'hA} || wlog[1] !== {5'd7, 32'hB}) begin
         n_err++; $display("FAIL fw_order: got %0d writes, first %h want 2 writes a then b", wlog.size(), (wlog.size() > 0) ? wlog[0] : 37'd0);
      end
      RD_A0 = 5'd0; RD_A1 = 5'd0;
   endtask

   task automatic test_full();
      bit ok;
      wlog.delete();
      RF_HOLD = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         ALU_VALID = 1'b1; ALU_ADDR = 5'(i + 1); ALU_DATA = 32'h100 + 32'(i);
         #1;
         n_cmp++; if (ALU_READY !== 1'b1) begin n_err++; $display("FAIL full_fill%0d: got %b want 1", i, ALU_READY); end
      end
      @(negedge CLK);
      ALU_ADDR = 5'd10; ALU_DATA = 32'h200; RF_HOLD = 1'b0;
      #1;
      n_cmp++; if (PEND_CNT !== 3'd4) begin n_err++; $display("FAIL full_cnt: got %0d want 4", PEND_CNT); end
      n_cmp++; if (ALU_READY !== 1'b0) begin n_err++; $display("FAIL full_pop_rdy: got %b want 0", ALU_READY); end
      n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL full_pop_we: got %b want 1", RF_WE); end
      @(negedge CLK);
      #1;
      n_cmp++; if (PEND_CNT !== 3'd3 || ALU_READY !== 1'b1) begin n_err++; $display("FAIL full_next: got cnt %0d rdy %b want 3 1", PEND_CNT, ALU_READY); end
      @(negedge CLK);
      ALU_VALID = 1'b0;
      #1;
      n_cmp++; if (PEND_CNT !== 3'd3) begin n_err++; $display("FAIL full_pushpop: got %0d want 3", PEND_CNT); end
      drain(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL full_drain: got cnt %0d want 0", PEND_CNT); end
      n_cmp++; if (wlog.size() !== 5) begin n_err++; $display("FAIL full_log_n: got %0d want 5", wlog.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++; if (wlog[i] !== {5'(i + 1), 32'h100 + 32'(i)}) begin n_err++; $display("FAIL full_log%0d: got %h", i, wlog[i]); end
         end
         n_cmp++; if (wlog[4] !== {5'd10, 32'h200}) begin n_err++; $display("FAIL full_log4: got %h want %h", wlog[4], {5'd10, 32'h200}); end
      end
   endtask

   task automatic test_reset_mid();
      wlog.delete();
      RF_HOLD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         LSU_VALID = 1'b1; LSU_ADDR = 5'(20 + i); LSU_DATA = 32'h300 + 32'(i);
      end
      @(negedge CLK);
      LSU_VALID = 1'b0;
      #1;
      n_cmp++; if (PEND_CNT !== 3'd3) begin n_err++; $display("FAIL mid_cnt: got %0d want 3", PEND_CNT); end
      RF_HOLD = 1'b0;
      #1;
      n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL mid_we_before: got %b want 1", RF_WE); end
      HW_RSTn = 1'b0;
      #1;
      n_cmp++; if (RF_WE !== 1'b0 || PEND_CNT !== 3'd0) begin n_err++; $display("FAIL mid_rst: got we %b cnt %0d want 0 0", RF_WE, PEND_CNT); end
      @(negedge CLK);
      HW_RSTn = 1'b1;
      repeat (3) @(negedge CLK);
      #1;
      n_cmp++; if (RF_WE !== 1'b0 || PEND_CNT !== 3'd0) begin n_err++; $display("FAIL mid_after: got we %b cnt %0d want 0 0", RF_WE, PEND_CNT); end
      n_cmp++; if (wlog.size() !== 0) begin n_err++; $display("FAIL mid_stale: got %0d writes want 0", wlog.size()); end
   endtask

   initial begin
      HW_RSTn = 1'b0; ALU_VALID = 1'b0; LSU_VALID = 1'b0; RF_HOLD = 1'b0;
      ALU_ADDR = '0; ALU_DATA = '0; LSU_ADDR = '0; LSU_DATA = '0;
      RD_A0 = '0; RD_A1 = '0; RF_DOUT0 = '0; RF_DOUT1 = '0;
      test_reset();
      test_round_robin();
      test_reg0();
      test_forward();
      test_full();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
